// File: rtl/ocp_pkg.sv
// Shared encodings for the OCP-style burst memory: command and response
// codes seen on the bus, plus the sequencer state type.
package ocp_pkg;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_WR_RESP,
    ST_RD_BURST,
    ST_ERR_RESP
  } state_t;

endpackage

// File: rtl/ocp_bytemask_ram.sv
// Single-port word array with per-byte write lanes and a registered read.
// Contents are deliberately not reset.
module ocp_bytemask_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic                    i_we,
  input  logic                    i_re,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane write and one-cycle registered read of the same address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BW; i++) begin
        if (i_be[i]) r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ocp_burst_mem.sv
// Burst memory for a single OCP-style master: fixed-length aligned bursts,
// byte-enabled writes, one-cycle write response, streamed read response.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | accepting commands; WR beat 0 may be written at accept
// ST_WR_BURST | collecting write beats base|cnt, stalls on DataValid=0
// ST_WR_RESP  | one-cycle DVA acknowledging the completed write burst
// ST_RD_BURST | DVA with read data for BURST_LEN consecutive cycles
// ST_ERR_RESP | one-cycle ERR for an illegal command
module ocp_burst_mem
  import ocp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              io_M_Cmd,
  input  logic [ADDR_WIDTH-1:0]   io_M_Addr,
  input  logic [DATA_WIDTH-1:0]   io_M_Data,
  input  logic                    io_M_DataValid,
  input  logic [DATA_WIDTH/8-1:0] io_M_DataByteEn,
  output logic                    io_S_CmdAccept,
  output logic                    io_S_DataAccept,
  output logic [1:0]              io_S_Resp,
  output logic [DATA_WIDTH-1:0]   io_S_Data
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(BURST_LEN - 1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(BURST_LEN - 1);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt, w_cmd_base, w_addr;
  logic                  w_we, w_re, w_rd_beat, w_last;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_cmd_base = io_M_Addr & ~BLK_MASK;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_last     = (r_cnt == CNT_LAST);

  // State, beat counter and burst base registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // Next-state, RAM control and bus outputs; reset forces everything quiet.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_base_nxt      = r_base;
    w_addr          = r_base | ADDR_WIDTH'(r_cnt);
    w_we            = 1'b0;
    w_re            = 1'b0;
    w_rd_beat       = 1'b0;
    io_S_CmdAccept  = 1'b0;
    io_S_DataAccept = 1'b0;
    io_S_Resp       = RESP_NULL;

    case (r_state)
      ST_IDLE: begin
        io_S_CmdAccept = 1'b1;
        w_addr         = w_cmd_base;
        case (io_M_Cmd)
          CMD_IDLE: ;
          CMD_WR: begin
            w_base_nxt  = w_cmd_base;
            w_state_nxt = ST_WR_BURST;
            if (io_M_DataValid) begin
              w_we            = 1'b1;
              io_S_DataAccept = 1'b1;
              w_cnt_nxt       = CW'(1);
            end else begin
              w_cnt_nxt = '0;
            end
          end
          CMD_RD: begin
            w_re        = 1'b1;
            w_base_nxt  = w_cmd_base;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RD_BURST;
          end
          default: w_state_nxt = ST_ERR_RESP;
        endcase
      end
      ST_WR_BURST: begin
        io_S_DataAccept = io_M_DataValid;
        if (io_M_DataValid) begin
          w_we = 1'b1;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WR_RESP;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_WR_RESP: begin
        io_S_Resp   = RESP_DVA;
        w_state_nxt = ST_IDLE;
      end
      ST_RD_BURST: begin
        // Prefetch the next beat so data streams without gaps; the fetch
        // issued on the last beat is simply never presented.
        io_S_Resp = RESP_DVA;
        w_rd_beat = 1'b1;
        w_re      = 1'b1;
        w_addr    = r_base | ADDR_WIDTH'(w_cnt_inc);
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_ERR_RESP: begin
        io_S_Resp   = RESP_ERR;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (reset) begin
      w_we            = 1'b0;
      w_re            = 1'b0;
      w_rd_beat       = 1'b0;
      io_S_CmdAccept  = 1'b0;
      io_S_DataAccept = 1'b0;
      io_S_Resp       = RESP_NULL;
    end
  end

  assign io_S_Data = w_rd_beat ? w_rdata : '0;

  ocp_bytemask_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_addr),
    .i_wdata (io_M_Data),
    .i_be    (io_M_DataByteEn),
    .i_we    (w_we),
    .i_re    (w_re),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_ocp_burst_mem.sv
// Directed bench for ocp_burst_mem with DATA_WIDTH=32, ADDR_WIDTH=8, BURST_LEN=4.
module tb_ocp_burst_mem;

  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b11;

  logic        clk;
  logic        reset;
  logic [2:0]  cmd;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        dvalid;
  logic [3:0]  be;
  logic        cmd_acc;
  logic        data_acc;
  logic [1:0]  resp;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  ocp_burst_mem #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .BURST_LEN  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_M_Cmd        (cmd),
    .io_M_Addr       (addr),
    .io_M_Data       (wdata),
    .io_M_DataValid  (dvalid),
    .io_M_DataByteEn (be),
    .io_S_CmdAccept  (cmd_acc),
    .io_S_DataAccept (data_acc),
    .io_S_Resp       (resp),
    .io_S_Data       (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd    = 3'b000;
    dvalid = 1'b0;
    wdata  = 32'h0;
    be     = 4'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [127:0] d, input logic [15:0] bes,
                          input int gaps, input bit late, input string tag);
    bit first = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0 || late) begin
        for (int g = 0; g < gaps; g++) begin
          cyc();
          idle_inputs();
          cmd  = first ? 3'b001 : 3'b000;
          addr = a;
          @(negedge clk);
          total++;
          if (data_acc !== 1'b0) begin
            bad++; $display("FAIL %s gap dataaccept beat%0d: got %b exp 0", tag, k, data_acc);
          end
          total++;
          if (resp !== R_NULL) begin
            bad++; $display("FAIL %s gap resp beat%0d: got %b exp 00", tag, k, resp);
          end
          total++;
          if (cmd_acc !== first) begin
            bad++; $display("FAIL %s gap cmdaccept beat%0d: got %b exp %b", tag, k, cmd_acc, first);
          end
          first = 1'b0;
        end
      end
      cyc();
      cmd    = first ? 3'b001 : 3'b000;
      addr   = a;
      dvalid = 1'b1;
      wdata  = d[k*32 +: 32];
      be     = bes[k*4 +: 4];
      @(negedge clk);
      total++;
      if (data_acc !== 1'b1) begin
        bad++; $display("FAIL %s dataaccept beat%0d: got %b exp 1", tag, k, data_acc);
      end
      total++;
      if (cmd_acc !== first) begin
        bad++; $display("FAIL %s cmdaccept beat%0d: got %b exp %b", tag, k, cmd_acc, first);
      end
      total++;
      if (resp !== R_NULL) begin
        bad++; $display("FAIL %s early resp beat%0d: got %b exp 00", tag, k, resp);
      end
      first = 1'b0;
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    total++;
    if (resp !== R_DVA) begin
      bad++; $display("FAIL %s write resp: got %b exp 01", tag, resp);
    end
    total++;
    if (rdata !== 32'h0) begin
      bad++; $display("FAIL %s write resp data: got %h exp 0", tag, rdata);
    end
    total++;
    if (cmd_acc !== 1'b0) begin
      bad++; $display("FAIL %s cmdaccept in resp: got %b exp 0", tag, cmd_acc);
    end
    cyc();
    @(negedge clk);
    total++;
    if (resp !== R_NULL || cmd_acc !== 1'b1) begin
      bad++; $display("FAIL %s back to idle: got resp %b acc %b exp 00 1", tag, resp, cmd_acc);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [127:0] e, input string tag);
    cyc();
    idle_inputs();
    cmd  = 3'b010;
    addr = a;
    @(negedge clk);
    total++;
    if (cmd_acc !== 1'b1 || resp !== R_NULL) begin
      bad++; $display("FAIL %s rd accept: got acc %b resp %b exp 1 00", tag, cmd_acc, resp);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      cmd = 3'b000;
      @(negedge clk);
      total++;
      if (resp !== R_DVA) begin
        bad++; $display("FAIL %s rd resp beat%0d: got %b exp 01", tag, k, resp);
      end
      total++;
      if (rdata !== e[k*32 +: 32]) begin
        bad++; $display("FAIL %s rd data beat%0d: got %h exp %h", tag, k, rdata, e[k*32 +: 32]);
      end
      total++;
      if (cmd_acc !== 1'b0) begin
        bad++; $display("FAIL %s rd cmdaccept beat%0d: got %b exp 0", tag, k, cmd_acc);
      end
    end
    cyc();
    @(negedge clk);
    total++;
    if (resp !== R_NULL || rdata !== 32'h0) begin
      bad++; $display("FAIL %s rd end: got resp %b data %h exp 00 0", tag, resp, rdata);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    addr   = 8'h00;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmd    = (i == 1) ? 3'b001 : 3'b000;
      dvalid = (i == 1);
      be     = 4'hF;
      @(negedge clk);
      total++;
      if (resp !== R_NULL || rdata !== 32'h0) begin
        bad++; $display("FAIL reset outputs c%0d: got resp %b data %h exp 00 0", i, resp, rdata);
      end
      total++;
      if (cmd_acc !== 1'b0 || data_acc !== 1'b0) begin
        bad++; $display("FAIL reset accepts c%0d: got %b%b exp 00", i, cmd_acc, data_acc);
      end
    end
    cyc();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if (cmd_acc !== 1'b1) begin
      bad++; $display("FAIL reset release cmdaccept: got %b exp 1", cmd_acc);
    end
  endtask

  task automatic test_write_read();
    do_write(8'h12, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF, 0, 1'b0, "wr12");
    do_read(8'h13, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "rd13");
  endtask

  task automatic test_byte_enable();
    do_write(8'h10, {4{32'hFFFF_FFFF}}, 16'h0005, 0, 1'b0, "wrbe");
    do_read(8'h10, {32'hA3, 32'hA2, 32'hA1, 32'h00FF_00FF}, "rdbe");
  endtask

  task automatic test_stall();
    do_write(8'hFC, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000},
             16'hFFFF, 2, 1'b1, "wrstall");
    do_read(8'hFE, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, "rdstall");
  endtask

  task automatic test_error();
    logic [2:0] ill [2];
    ill[0] = 3'b011;
    ill[1] = 3'b111;
    for (int i = 0; i < 2; i++) begin
      cyc();
      cmd    = ill[i];
      addr   = 8'h10;
      dvalid = 1'b1;
      wdata  = 32'hDEAD_BEEF;
      be     = 4'hF;
      @(negedge clk);
      total++;
      if (cmd_acc !== 1'b1 || data_acc !== 1'b0) begin
        bad++; $display("FAIL err accept %0d: got acc %b dacc %b exp 1 0", i, cmd_acc, data_acc);
      end
      cyc();
      idle_inputs();
      @(negedge clk);
      total++;
      if (resp !== R_ERR || rdata !== 32'h0) begin
        bad++; $display("FAIL err resp %0d: got %b data %h exp 11 0", i, resp, rdata);
      end
      cyc();
      @(negedge clk);
      total++;
      if (resp !== R_NULL || cmd_acc !== 1'b1) begin
        bad++; $display("FAIL err end %0d: got resp %b acc %b exp 00 1", i, resp, cmd_acc);
      end
    end
    do_read(8'h10, {32'hA3, 32'hA2, 32'hA1, 32'h00FF_00FF}, "rderr");
  endtask

  task automatic test_reset_mid_burst();
    do_write(8'h20, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'hFFFF, 0, 1'b0, "wrold");
    cyc();
    cmd = 3'b001; addr = 8'h21; dvalid = 1'b1; wdata = 32'hD0; be = 4'hF;
    cyc();
    cmd = 3'b000; wdata = 32'hD1;
    cyc();
    reset = 1'b1; wdata = 32'hD2;
    @(negedge clk);
    total++;
    if (resp !== R_NULL || data_acc !== 1'b0 || cmd_acc !== 1'b0) begin
      bad++; $display("FAIL midrst outputs: got resp %b dacc %b acc %b exp 00 0 0",
                      resp, data_acc, cmd_acc);
    end
    cyc();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if (cmd_acc !== 1'b1 || resp !== R_NULL) begin
      bad++; $display("FAIL midrst idle: got acc %b resp %b exp 1 00", cmd_acc, resp);
    end
    do_read(8'h20, {32'hC3, 32'hC2, 32'hD1, 32'hD0}, "rdmid");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_stall();
    test_error();
    test_reset_mid_burst();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
